// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMips fetch/decode sequencer: instruction
// layout, opcode and sequencer state encodings.
package picomips_pkg;

  localparam int IW     = 16;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LDI    = 4'd1,
    OP_LDR    = 4'd2,
    OP_ADDI   = 4'd3,
    OP_ADDR   = 4'd4,
    OP_MULI   = 4'd5,
    OP_STR    = 4'd6,
    OP_JMP    = 4'd7,
    OP_BZ     = 4'd8,
    OP_WAITSW = 4'd9,
    OP_HALT   = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/picomips_decode.sv
// Combinational instruction decode: turns the latched IR into ALU strobes,
// register-file write, PC-load and EXEC-completion signals.
module picomips_decode
  import picomips_pkg::*;
(
  input  logic [IW-1:0] ir_i,
  input  logic          exec_i,
  input  logic [7:0]    acc_i,
  input  logic          sw_valid_i,
  output logic          sel_sw_o,
  output logic          sel_imm_o,
  output logic          sel_reg_o,
  output logic          use_mul_o,
  output logic          use_acc_o,
  output logic          we_o,
  output logic          reg_we_o,
  output logic          jump_o,
  output logic          done_o,
  output logic          halt_o
);

  opcode_t op;
  assign op = opcode_t'(ir_i[OP_HI:OP_LO]);

  always_comb begin
    sel_sw_o  = 1'b0;
    sel_imm_o = 1'b0;
    sel_reg_o = 1'b0;
    use_mul_o = 1'b0;
    use_acc_o = 1'b0;
    we_o      = 1'b0;
    reg_we_o  = 1'b0;
    jump_o    = 1'b0;
    done_o    = 1'b1;
    halt_o    = 1'b0;
    if (exec_i) begin
      case (op)
        OP_LDI:  begin sel_imm_o = 1'b1; we_o = 1'b1; end
        OP_LDR:  begin sel_reg_o = 1'b1; we_o = 1'b1; end
        OP_ADDI: begin sel_imm_o = 1'b1; use_acc_o = 1'b1; we_o = 1'b1; end
        OP_ADDR: begin sel_reg_o = 1'b1; use_acc_o = 1'b1; we_o = 1'b1; end
        OP_MULI: begin use_mul_o = 1'b1; use_acc_o = 1'b1; we_o = 1'b1; end
        OP_STR:  reg_we_o = 1'b1;
        OP_JMP:  jump_o = 1'b1;
        OP_BZ:   jump_o = (acc_i == 8'd0);
        // Parks in EXEC until the switch is valid, loading it that same cycle
        OP_WAITSW: begin
          done_o   = sw_valid_i;
          sel_sw_o = sw_valid_i;
          we_o     = sw_valid_i;
        end
        OP_HALT: halt_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/picomips_ctrl.sv
// picoMips fetch/decode sequencer: FETCH/EXEC/HALT FSM, PC and IR.
// Define PICOMIPS_RELBRANCH_EN for PC-relative JMP/BZ targets (default absolute).
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int PCW = 8,
  parameter int RAW = 4
) (
  input  logic           Clock,
  input  logic           nReset,
  output logic [PCW-1:0] IAddr,
  output logic           IReq,
  input  logic           IAck,
  input  logic [IW-1:0]  IData,
  input  logic [7:0]     Acc,
  input  logic           SwValid,
  output logic [7:0]     Imm,
  output logic           WE,
  output logic           SelSW,
  output logic           SelImm,
  output logic           SelRegData,
  output logic           UseMul,
  output logic           UseACC,
  output logic [RAW-1:0] RegAddr,
  output logic           RegWE,
  output logic           Halted
);

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d, target;
  logic [IW-1:0]  ir_q, ir_d;
  logic           jump, done, halt;

`ifdef PICOMIPS_RELBRANCH_EN
  // pc_q already points past the branch, so the offset is from the next instruction
  logic signed [7:0] imm_s;
  assign imm_s  = signed'(ir_q[IMM_HI:IMM_LO]);
  assign target = pc_q + PCW'(imm_s);
`else
  assign target = PCW'(ir_q[IMM_HI:IMM_LO]);
`endif

  picomips_decode u_decode (
    .ir_i       (ir_q),
    .exec_i     (state_q == S_EXEC),
    .acc_i      (Acc),
    .sw_valid_i (SwValid),
    .sel_sw_o   (SelSW),
    .sel_imm_o  (SelImm),
    .sel_reg_o  (SelRegData),
    .use_mul_o  (UseMul),
    .use_acc_o  (UseACC),
    .we_o       (WE),
    .reg_we_o   (RegWE),
    .jump_o     (jump),
    .done_o     (done),
    .halt_o     (halt)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (IAck) begin
          ir_d    = IData;
          pc_d    = pc_q + PCW'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (jump) pc_d = target;
        if (halt)      state_d = S_HALT;
        else if (done) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Gating with nReset drops the request the instant reset asserts
  assign IReq    = (state_q == S_FETCH) && nReset;
  assign IAddr   = pc_q;
  assign Halted  = (state_q == S_HALT);
  assign Imm     = ir_q[IMM_HI:IMM_LO];
  assign RegAddr = RAW'(ir_q[RA_HI:RA_LO]);

endmodule
